bcd_counter_display: RTL and testbench

//  Datapath sitting directly inside VirtualBoard. Divides CLOCK (10 MHz from the PLL) down to
//  a count tick and drives an 8-digit up/down BCD counter. Run/stop and clear come from the

---
 rtl/bcd_counter_display_if.sv | 17 +
 rtl/bcd_counter_display.sv | 149 ++++++++++++++
 tb/tb_bcd_counter_display.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_display_if.sv
// bcd_counter_display_if
//  Board-side signal bundle for the BCD counter datapath.
//  PB_RUN / PB_CLR / SW_DOWN : scan-chain buttons and switch (asynchronous to CLOCK)
//  L_RUN / L_TICK            : status LEDs
//  SD[k]                     : 7-segment byte {dp,g,f,e,d,c,b,a} for digit k (SD[0] = LSD)
//  master = board / scan-chain side, slave = counter datapath.
interface bcd_counter_display_if;
    logic            PB_RUN;
    logic            PB_CLR;
    logic            SW_DOWN;
    logic            L_RUN;
    logic            L_TICK;
    logic [7:0][7:0] SD;

    modport master (output PB_RUN, PB_CLR, SW_DOWN, input  L_RUN, L_TICK, SD);
    modport slave  (input  PB_RUN, PB_CLR, SW_DOWN, output L_RUN, L_TICK, SD);
endinterface

// File: rtl/bcd_counter_display.sv
// bcd_counter_display
//  Divides CLOCK down to a count tick and drives an 8-digit up/down BCD counter whose
//  digits are shown as registered 7-segment bytes.
//  Ports:
//   CLOCK   system clock
//   RESETn  asynchronous active-low reset
//   bus     bcd_counter_display_if.slave (buttons/switch in, LEDs and segment bytes out)
//  Parameters:
//   DIV     CLOCK cycles per count tick (>= 2)
//   SEG_ON  level of a lit segment (0 = active-low)

// One BCD digit register; steps up or down by one when step is set.
module bcd_digit (
    input  logic       CLOCK,
    input  logic       RESETn,
    input  logic       clr,
    input  logic       step,
    input  logic       down,
    output logic [3:0] digit
);
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn)
            digit <= 4'd0;
        else if (clr)
            digit <= 4'd0;
        else if (step) begin
            if (down)
                digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            else
                digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end
endmodule

module bcd_counter_display #(
    parameter int   DIV    = 10_000_000,
    parameter logic SEG_ON = 1'b0
) (
    input  logic                  CLOCK,
    input  logic                  RESETn,
    bcd_counter_display_if.slave  bus
);
    localparam int NUM_DIGITS = 8;
    localparam int DW         = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [1:0] run_sync, clr_sync, down_sync;
    logic       run_prev, clr_prev;
    logic       run_rise, clr_rise, down_s;
    logic       run, tick, tick_q;
    logic [DW-1:0] div;

    logic [NUM_DIGITS-1:0]      step;
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0][7:0] sd;

    // Board codes are active-low; SEG_ON=1 inverts every bit. Unused codes stay blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return SEG_ON ? ~c : c;
    endfunction

    // Two-flop synchronizers plus a previous-value register for edge detection.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            run_sync  <= 2'b00;
            clr_sync  <= 2'b00;
            down_sync <= 2'b00;
            run_prev  <= 1'b0;
            clr_prev  <= 1'b0;
        end else begin
            run_sync  <= {run_sync[0],  bus.PB_RUN};
            clr_sync  <= {clr_sync[0],  bus.PB_CLR};
            down_sync <= {down_sync[0], bus.SW_DOWN};
            run_prev  <= run_sync[1];
            clr_prev  <= clr_sync[1];
        end
    end

    assign run_rise = run_sync[1] & ~run_prev;
    assign clr_rise = clr_sync[1] & ~clr_prev;
    assign down_s   = down_sync[1];

    // Tick is judged on the pre-toggle RUN; a clear in the same cycle cancels it.
    assign tick = run & (div == DIV_LAST) & ~clr_rise;

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            run    <= 1'b0;
            div    <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (run_rise)
                run <= ~run;
            if (clr_rise)
                div <= '0;
            else if (run)
                div <= (div == DIV_LAST) ? '0 : div + DW'(1);
        end
    end

    // Ripple carry/borrow: a digit steps when every lower digit is at its wrap limit.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign step[i] = tick;
        end else begin : g_upper
            assign step[i] = step[i-1] &
                             (down_s ? (digits[i-1] == 4'd0) : (digits[i-1] == 4'd9));
        end

        bcd_digit u_digit (
            .CLOCK  (CLOCK),
            .RESETn (RESETn),
            .clr    (clr_rise),
            .step   (step[i]),
            .down   (down_s),
            .digit  (digits[i])
        );
    end

    // Segment bytes trail the digit registers by one cycle.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                sd[i] <= seg_encode(4'd0);
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
                sd[i] <= seg_encode(digits[i]);
        end
    end

    assign bus.L_RUN  = run;
    assign bus.L_TICK = tick_q;
    assign bus.SD     = sd;
endmodule

// File: tb/tb_bcd_counter_display.sv
module tb_bcd_counter_display;
    localparam int DIV  = 4;
    localparam int MODN = 100_000_000;

    logic CLOCK  = 1'b0;
    logic RESETn = 1'b0;
    logic pb_run = 1'b0, pb_clr = 1'b0, sw_down = 1'b0;

    always #5 CLOCK = ~CLOCK;

    bcd_counter_display_if bus0 ();
    bcd_counter_display_if bus1 ();

    assign bus0.PB_RUN  = pb_run;
    assign bus0.PB_CLR  = pb_clr;
    assign bus0.SW_DOWN = sw_down;
    assign bus1.PB_RUN  = pb_run;
    assign bus1.PB_CLR  = pb_clr;
    assign bus1.SW_DOWN = sw_down;

    bcd_counter_display #(.DIV(DIV), .SEG_ON(1'b0)) dut0 (.CLOCK(CLOCK), .RESETn(RESETn), .bus(bus0));
    bcd_counter_display #(.DIV(DIV), .SEG_ON(1'b1)) dut1 (.CLOCK(CLOCK), .RESETn(RESETn), .bus(bus1));

    int vectors = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    // Button/switch samples per edge; index 0 is the most recent sample.
    logic [2:0] rh = '0, ch = '0, dh = '0;
    int  m_run = 0, m_div = 0, m_cnt = 0, m_sd_cnt = 0, m_ticks = 0;
    bit  m_tick = 0;

    always @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            rh = '0; ch = '0; dh = '0;
            m_run = 0; m_div = 0; m_cnt = 0; m_sd_cnt = 0; m_tick = 0;
        end else begin
            bit rr, cr, dn;
            // An input change reaches the edge detector two edges later; the effect lands on the third.
            rr = rh[1] & ~rh[2];
            cr = ch[1] & ~ch[2];
            dn = dh[1];
            m_sd_cnt = m_cnt;
            m_tick = (m_run != 0) && (m_div == DIV - 1) && !cr;
            if (cr) begin
                m_cnt = 0;
                m_div = 0;
            end else begin
                if (m_run != 0) m_div = (m_div + 1) % DIV;
                if (m_tick) begin
                    m_cnt = dn ? (m_cnt + MODN - 1) % MODN : (m_cnt + 1) % MODN;
                    m_ticks++;
                end
            end
            if (rr) m_run = (m_run == 0) ? 1 : 0;
            rh = {rh[1:0], pb_run};
            ch = {ch[1:0], pb_clr};
            dh = {dh[1:0], sw_down};
        end
    end

    function automatic logic [7:0] seg_of(int cnt, int k, bit on);
        int d = cnt;
        logic [7:0] c;
        for (int i = 0; i < k; i++) d = d / 10;
        d = d % 10;
        case (d)
            0: c = 8'hC0; 1: c = 8'hF9; 2: c = 8'hA4; 3: c = 8'hB0; 4: c = 8'h99;
            5: c = 8'h92; 6: c = 8'h82; 7: c = 8'hF8; 8: c = 8'h80; default: c = 8'h90;
        endcase
        return on ? ~c : c;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge CLOCK) begin
        chk("L_RUN", 8'(bus0.L_RUN), 8'(m_run));
        chk("L_TICK", 8'(bus0.L_TICK), 8'(m_tick));
        chk("L_RUN_inv", 8'(bus1.L_RUN), 8'(m_run));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("SD%0d", k), bus0.SD[k], seg_of(m_sd_cnt, k, 1'b0));
            chk($sformatf("SD%0d_inv", k), bus1.SD[k], seg_of(m_sd_cnt, k, 1'b1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic wait_ticks_to(input int target);
        int budget = (target - m_ticks) * DIV * 4 + 40;
        while (m_ticks < target && budget > 0) begin
            @(negedge CLOCK);
            budget--;
        end
        vectors++;
        if (m_ticks < target) begin
            miscompares++;
            $display("FAIL wait_ticks timeout: got %0d ticks expected %0d", m_ticks, target);
        end
    endtask

    task automatic check_all_sd(input string name, input logic [7:0] code);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_SD%0d", name, k), bus0.SD[k], code);
    endtask

    initial begin
        int guard;
        cyc(3);
        chk("reset_SD0", bus0.SD[0], 8'hC0);
        chk("reset_SD0_inv", bus1.SD[0], 8'h3F);
        chk("reset_L_RUN", 8'(bus0.L_RUN), 8'h00);
        RESETn = 1'b1;

        // Idle: nothing may move.
        cyc(100);
        chk("idle_L_RUN", 8'(bus0.L_RUN), 8'h00);
        check_all_sd("idle", 8'hC0);

        // Start: RUN rises on the third edge after the press.
        pb_run = 1'b1;
        cyc(2);
        chk("run_lat_pre", 8'(bus0.L_RUN), 8'h00);
        cyc(1);
        chk("run_lat", 8'(bus0.L_RUN), 8'h01);
        cyc(7);
        pb_run = 1'b0;
        wait_ticks_to(12);
        cyc(1);
        chk("twelve_SD0", bus0.SD[0], 8'hA4);
        chk("twelve_SD1", bus0.SD[1], 8'hF9);
        chk("twelve_SD2", bus0.SD[2], 8'hC0);

        // Clear edge lands exactly on the tick cycle.
        guard = 0;
        while (m_div != 1 && guard < 20) begin cyc(1); guard++; end
        pb_clr = 1'b1;
        cyc(3);
        chk("clr_vs_tick", 8'(bus0.L_TICK), 8'h00);
        cyc(1);
        pb_clr = 1'b0;
        chk("clr_SD0", bus0.SD[0], 8'hC0);
        chk("clr_SD1", bus0.SD[1], 8'hC0);
        cyc(3);
        chk("tick_after_clr", 8'(bus0.L_TICK), 8'h01);

        // Down from zero wraps to all nines, then up wraps back to zero.
        sw_down = 1'b1;
        pb_clr  = 1'b1;
        cyc(2);
        pb_clr = 1'b0;
        wait_ticks_to(m_ticks + 1);
        cyc(1);
        check_all_sd("down_wrap", 8'h90);
        sw_down = 1'b0;
        wait_ticks_to(m_ticks + 1);
        cyc(1);
        check_all_sd("up_wrap", 8'hC0);
        chk("up_wrap_inv_SD0", bus1.SD[0], 8'h3F);

        // Hold-to-pause at 5, stays put, then resumes mid-interval.
        wait_ticks_to(m_ticks + 5);
        pb_run = 1'b1;
        cyc(50);
        pb_run = 1'b0;
        chk("hold_once", 8'(bus0.L_RUN), 8'h00);
        cyc(40);
        chk("pause_SD0", bus0.SD[0], 8'h92);
        chk("pause_L_RUN", 8'(bus0.L_RUN), 8'h00);
        pb_run = 1'b1;
        cyc(3);
        chk("restart", 8'(bus0.L_RUN), 8'h01);
        pb_run = 1'b0;
        cyc(1);
        chk("resume_tick", 8'(bus0.L_TICK), 8'h01);

        // Asynchronous reset between edges.
        cyc(6);
        @(posedge CLOCK);
        #2 RESETn = 1'b0;
        #1;
        chk("async_L_RUN", 8'(bus0.L_RUN), 8'h00);
        chk("async_L_TICK", 8'(bus0.L_TICK), 8'h00);
        chk("async_SD0", bus0.SD[0], 8'hC0);
        chk("async_SD0_inv", bus1.SD[0], 8'h3F);
        @(negedge CLOCK);
        RESETn = 1'b1;

        // Random buttons, direction flips and the odd mid-cycle reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLOCK);
            if ($urandom_range(0, 39) == 0) pb_run  = ~pb_run;
            if ($urandom_range(0, 59) == 0) pb_clr  = ~pb_clr;
            if ($urandom_range(0, 49) == 0) sw_down = ~sw_down;
            if ($urandom_range(0, 799) == 0) begin
                #3 RESETn = 1'b0;
                @(negedge CLOCK);
                RESETn = 1'b1;
            end
        end

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
